alu_cmd_queue: RTL and testbench

ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_cmd_fifo.sv | 71 +++++++
 rtl/alu_cmd_queue.sv | 110 +++++++++++
 tb/tb_alu_cmd_queue.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU command definitions: op encodings, command/result records, legality check.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    // ALU control encodings understood by the downstream ALU
    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;

    // One queued command: operands plus control code (19 bits)
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // One captured result as presented on the output handshake
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              carry;
        logic              zero;
        logic              err;
    } res_t;

    // Codes above XOR have no ALU meaning; they still flow through the queue
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO holding ALU commands, DEPTH entries (power of two), first-word fall-through head.
// Latency: a pushed entry is visible at rd_dat after the next rising edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates with full/empty.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wr_dat,
    input  logic         pop,
    output logic [W-1:0] rd_dat,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic push_ok;
    logic pop_ok;

    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_dat  = mem[rd_ptr];

    // Storage is not reset: stale entries are unreachable once pointers/count clear
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_queue.sv
// Queues ALU commands, drives an external combinational ALU from the queue head, registers its result.
// Latency: 1 cycle minimum from command accept to out_valid; no input-to-output bypass.
// Backpressure: in_ready low when queue full or in reset; output register held while out_ready low.
module alu_cmd_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [OP_W-1:0]   in_op,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_control,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_carry,
    output logic              out_zero,
    output logic              out_err
);

    cmd_t wr_cmd;
    cmd_t head_cmd;
    res_t cap;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic out_free;
    logic head_legal;

    assign wr_cmd = '{a: in_a, b: in_b, op: in_op};

    // Full-only check: a full queue refuses even if a pop happens on the same edge
    assign in_ready = !rst && !fifo_full;
    assign push     = in_valid && in_ready;

    // Output register can take a new result when empty or being drained this edge
    assign out_free = !out_valid || out_ready;
    assign pop      = !fifo_empty && out_free;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wr_dat (wr_cmd),
        .pop    (pop),
        .rd_dat (head_cmd),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // ALU inputs come from the head entry; quiet zeros when nothing is queued
    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_control = '0;
        if (!fifo_empty) begin
            alu_a       = head_cmd.a;
            alu_b       = head_cmd.b;
            alu_control = head_cmd.op;
        end
    end

    // Illegal ops ignore whatever the ALU returns and report a clean zero result
    always_comb begin
        head_legal = is_legal_op(head_cmd.op);
        cap        = '0;
        if (head_legal) begin
            cap.result = alu_result;
            cap.carry  = alu_carry;
        end
        cap.zero = (cap.result == '0);
        cap.err  = !head_legal;
    end

    // Result register: capture on pop, otherwise drop valid once consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_carry  <= 1'b0;
            out_zero   <= 1'b0;
            out_err    <= 1'b0;
        end else if (pop) begin
            out_valid  <= 1'b1;
            out_result <= cap.result;
            out_carry  <= cap.carry;
            out_zero   <= cap.zero;
            out_err    <= cap.err;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed bench for alu_cmd_queue with a behavioural external ALU.
// Latency: checks 1-cycle accept-to-valid and 1/cycle streaming.
// Backpressure: exercises full queue, held output, and reset flush.
module tb_alu_cmd_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_control;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic       out_carry;
    logic       out_zero;
    logic       out_err;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    logic [10:0] got_q[$];
    int          got_cyc[$];
    logic [10:0] exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    alu_cmd_queue #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_carry   (alu_carry),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_carry   (out_carry),
        .out_zero    (out_zero),
        .out_err     (out_err)
    );

    // External ALU; illegal codes return junk that the DUT must suppress
    always_comb begin
        {alu_carry, alu_result} = 9'h000;
        case (alu_control)
            3'b000:  {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001:  {alu_carry, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            default: {alu_carry, alu_result} = {1'b1, 8'hA5};
        endcase
    end

    // Record each result on the half-cycle before the edge that consumes it
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_q.push_back({out_result, out_carry, out_zero, out_err});
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command, wait (bounded) for acceptance, queue its expected result
    task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                            input logic [10:0] exp);
        bit acc;
        acc      = 1'b0;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_valid = 1'b1;
        for (int w = 0; w < 50 && !acc; w++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
        end
        check("push_accept", 32'(acc), 32'd1);
        if (acc) begin
            tick();
            exp_q.push_back(exp);
        end else begin
            in_valid = 1'b0;
        end
    endtask

    // Wait (bounded) for n results, then compare against the expected queue in order
    task automatic drain_check(input string name, input int n);
        for (int w = 0; w < 100 && got_q.size() < n; w++) @(negedge clk);
        check({name, "_count"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n && i < got_q.size() && i < exp_q.size(); i++)
            check({name, "_data"}, 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic clear_q();
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       e;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    initial begin
        int t0;
        logic [7:0] sa, sb, ss;

        vecs[0]  = '{8'h7F, 8'h01, 3'b000, 8'h80, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'hFF, 8'h01, 3'b000, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{8'h05, 8'h06, 3'b001, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{8'hAA, 8'h55, 3'b110, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{8'hF0, 8'h3C, 3'b010, 8'h30, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{8'hF0, 8'h0F, 3'b011, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{8'h5A, 8'h5A, 3'b100, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{8'h10, 8'h10, 3'b001, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{8'h33, 8'h44, 3'b111, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{8'h0F, 8'hF0, 3'b101, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{8'h01, 8'h02, 3'b000, 8'h03, 1'b0, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        in_op     = 3'b000;
        out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", 32'(out_result), 32'd0);
        check("rst_out_flags", 32'({out_carry, out_zero, out_err}), 32'd0);
        check("rst_alu_in", 32'({alu_a, alu_b, alu_control}), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single commands through an idle queue, latency checked per vector
        for (int i = 0; i < NV; i++) begin
            check("tbl_in_ready", 32'(in_ready), 32'd1);
            in_a     = vecs[i].a;
            in_b     = vecs[i].b;
            in_op    = vecs[i].op;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            check("tbl_head", 32'({alu_a, alu_b, alu_control}),
                  32'({vecs[i].a, vecs[i].b, vecs[i].op}));
            check("tbl_no_bypass", 32'(out_valid), 32'd0);
            @(negedge clk);
            check("tbl_out_valid", 32'(out_valid), 32'd1);
            check("tbl_result", 32'(out_result), 32'(vecs[i].res));
            check("tbl_flags", 32'({out_carry, out_zero, out_err}),
                  32'({vecs[i].c, vecs[i].z, vecs[i].e}));
            @(negedge clk);
            check("tbl_consumed", 32'(out_valid), 32'd0);
        end

        // Backpressure: first result captured, four queued, sixth held until drain
        tick();
        clear_q();
        out_ready = 1'b0;
        push_cmd(8'h01, 8'h02, 3'b000, {8'h03, 1'b0, 1'b0, 1'b0});
        push_cmd(8'h80, 8'h80, 3'b000, {8'h00, 1'b1, 1'b1, 1'b0});
        push_cmd(8'h0F, 8'hF0, 3'b011, {8'hFF, 1'b0, 1'b0, 1'b0});
        push_cmd(8'hFF, 8'h0F, 3'b010, {8'h0F, 1'b0, 1'b0, 1'b0});
        push_cmd(8'h00, 8'h01, 3'b001, {8'hFF, 1'b1, 1'b0, 1'b0});
        in_a  = 8'h3C;
        in_b  = 8'hC3;
        in_op = 3'b100;
        @(negedge clk);
        check("bp_full_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_first_result", 32'(out_result), 32'h03);
        tick();
        tick();
        @(negedge clk);
        check("bp_still_full", 32'(in_ready), 32'd0);
        check("bp_hold_result", 32'({out_result, out_carry, out_zero, out_err}),
              32'({8'h03, 1'b0, 1'b0, 1'b0}));
        tick();
        out_ready = 1'b1;
        push_cmd(8'h3C, 8'hC3, 3'b100, {8'hFF, 1'b0, 1'b0, 1'b0});
        in_valid = 1'b0;
        drain_check("bp", 6);

        // Reset mid-operation: three queued plus a pending result are discarded
        tick();
        clear_q();
        out_ready = 1'b0;
        push_cmd(8'h11, 8'h22, 3'b000, 11'h0);
        push_cmd(8'h33, 8'h44, 3'b000, 11'h0);
        push_cmd(8'h55, 8'h66, 3'b000, 11'h0);
        push_cmd(8'h77, 8'h01, 3'b000, 11'h0);
        in_valid = 1'b0;
        @(negedge clk);
        check("mr_pending_valid", 32'(out_valid), 32'd1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("mr_in_ready_in_rst", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_in_ready", 32'(in_ready), 32'd1);
        check("mr_alu_in", 32'({alu_a, alu_b, alu_control}), 32'd0);
        check("mr_out_regs", 32'({out_result, out_carry, out_zero, out_err}), 32'd0);
        tick();
        clear_q();
        out_ready = 1'b1;
        repeat (6) tick();
        check("mr_no_replay", 32'(got_q.size()), 32'd0);
        push_cmd(8'h12, 8'h34, 3'b000, {8'h46, 1'b0, 1'b0, 1'b0});
        in_valid = 1'b0;
        drain_check("mr_after", 1);

        // Streaming: 20 back-to-back commands, pointers wrap five times
        tick();
        clear_q();
        t0 = cyc;
        for (int i = 0; i < 20; i++) begin
            sa = 8'(i * 9);
            sb = 8'(i * 3);
            ss = 8'(i * 12);
            push_cmd(sa, sb, 3'b000, {ss, 1'b0, (ss == 8'h00), 1'b0});
        end
        in_valid = 1'b0;
        check("st_in_rate", 32'(cyc - t0), 32'd20);
        drain_check("st", 20);
        if (got_cyc.size() == 20)
            check("st_out_rate", 32'(got_cyc[19] - got_cyc[0]), 32'd19);
        else
            check("st_out_rate_n", 32'(got_cyc.size()), 32'd20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
